// File: rtl/lib_switchblock_pkg.sv
// Shared definitions for the DEM switching-tree family.
//   DEM_INPUT_WIDTH   : default code width (signed two's complement)
//   dem_mode_e        : per-sample switching mode
//   LFSR_TAPS         : 16-bit Fibonacci LFSR taps 16,14,13,11 as a bit mask
//   LFSR_DEFAULT_SEED : default non-zero LFSR reset value
package lib_switchblock_pkg;

   localparam int          DEM_INPUT_WIDTH   = 16;
   localparam logic [15:0] LFSR_TAPS         = 16'hB400;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

   typedef enum logic [1:0] {
      DEM_STATIC  = 2'b00,
      DEM_SHAPED  = 2'b01,
      DEM_RANDOM  = 2'b10,
      DEM_ILLEGAL = 2'b11
   } dem_mode_e;

endpackage

// File: rtl/dem_switch_node.sv
// One registered DEM split node.
//   clk_i, reset_i : clock, synchronous active-high reset
//   valid_i        : stage input valid; output registers and state bit only move on it
//   mode_i         : switching mode travelling with this sample
//   rand_bit_i     : this node's LFSR bit captured with the sample
//   x_i            : node value
//   a_o / b_o      : left / right child, a_o + b_o == x_i
module dem_switch_node
   import lib_switchblock_pkg::*;
#(
   parameter int WIDTH = DEM_INPUT_WIDTH
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    valid_i,
   input  dem_mode_e               mode_i,
   input  logic                    rand_bit_i,
   input  logic signed [WIDTH-1:0] x_i,
   output logic signed [WIDTH-1:0] a_o,
   output logic signed [WIDTH-1:0] b_o
);

   localparam logic signed [WIDTH-1:0] ONE = 1;

   logic                    p_q;
   logic                    odd;
   logic                    s_pos;
   logic signed [WIDTH-1:0] half;
   logic signed [WIDTH-1:0] a_d;
   logic signed [WIDTH-1:0] b_d;

   // (x+s)>>>1 and (x-s)>>>1 rewritten as floor(x/2) plus a carry of one
   // into whichever child the sign of s favours; cannot overflow WIDTH.
   always_comb begin
      odd = x_i[0];
      case (mode_i)
         DEM_SHAPED: s_pos = ~p_q;
         DEM_RANDOM: s_pos = rand_bit_i;
         default:    s_pos = 1'b1;   // static and illegal
      endcase
      half = x_i >>> 1;
      a_d  = half;
      b_d  = half;
      if (odd) begin
         if (s_pos) a_d = half + ONE;
         else       b_d = half + ONE;
      end
   end

   // p follows every valid odd value so shaping stays first-order even
   // across mode changes.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         p_q <= 1'b0;
         a_o <= '0;
         b_o <= '0;
      end else if (valid_i) begin
         if (odd) p_q <= ~p_q;
         a_o <= a_d;
         b_o <= b_d;
      end
   end

endmodule

// File: rtl/dem_switch_tree.sv
// Parametrised DEM switching tree: splits a signed code into 2**NUM_LAYERS
// unit-element codes through NUM_LAYERS registered split stages.
//   clk_i, reset_i : clock, synchronous active-high reset
//   valid_i        : input sample valid
//   mode_i         : 00 static, 01 shaped, 10 random, 11 illegal (runs as static)
//   x_in_i         : signed input code
//   valid_o        : valid_i delayed NUM_LAYERS cycles
//   x_out_o        : leaf j at [j*INPUT_WIDTH +: INPUT_WIDTH]
//   zero_flag_o    : output sample was zero
//   mode_err_o     : output sample was launched with mode 11
//   sum_err_o      : leaf sum differs from delayed input
module dem_switch_tree
   import lib_switchblock_pkg::*;
#(
   parameter int          INPUT_WIDTH = DEM_INPUT_WIDTH,
   parameter int          NUM_LAYERS  = 3,
   parameter logic [15:0] LFSR_SEED   = LFSR_DEFAULT_SEED
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,
   input  logic                                   valid_i,
   input  logic [1:0]                             mode_i,
   input  logic signed [INPUT_WIDTH-1:0]          x_in_i,
   output logic                                   valid_o,
   output logic [(2**NUM_LAYERS)*INPUT_WIDTH-1:0] x_out_o,
   output logic                                   zero_flag_o,
   output logic                                   mode_err_o,
   output logic                                   sum_err_o
);

   localparam int NUM_LEAVES = 2**NUM_LAYERS;
   localparam int NUM_NODES  = NUM_LEAVES - 1;
   localparam int SUM_W      = INPUT_WIDTH + NUM_LAYERS;

   // stage k signals: index 0 is the live input, k>0 the registered copy
   logic [NUM_LAYERS:0]                      vld_pipe;
   logic [NUM_LAYERS-1:0]                    vld_q;
   dem_mode_e                                mode_pipe [NUM_LAYERS+1];
   dem_mode_e                                mode_q    [NUM_LAYERS];
   logic [NUM_LAYERS:0][INPUT_WIDTH-1:0]     x_pipe;
   logic [NUM_LAYERS-1:0][INPUT_WIDTH-1:0]   x_q;
   logic [15:0]                              lfsr_q;
   logic [NUM_LEAVES-1:0][INPUT_WIDTH-1:0]   leaves;
   logic [SUM_W-1:0]                         leaf_sum;

   always_comb begin
      vld_pipe     = {vld_q, valid_i};
      x_pipe       = {x_q, x_in_i};
      mode_pipe[0] = dem_mode_e'(mode_i);
      for (int k = 0; k < NUM_LAYERS; k++) mode_pipe[k+1] = mode_q[k];
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         vld_q  <= '0;
         x_q    <= '0;
         lfsr_q <= LFSR_SEED;
         for (int k = 0; k < NUM_LAYERS; k++) mode_q[k] <= DEM_STATIC;
      end else begin
         vld_q <= vld_pipe[NUM_LAYERS-1:0];
         for (int k = 0; k < NUM_LAYERS; k++) begin
            if (vld_pipe[k]) begin
               mode_q[k] <= mode_pipe[k];
               x_q[k]    <= x_pipe[k];
            end
         end
         if (valid_i) lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
      end
   end

   // Each layer carries only the random bits of its own and deeper nodes
   // (flat node index k uses LFSR bit k mod 16), dropping its own bits as
   // the sample moves on.
   for (genvar l = 0; l < NUM_LAYERS; l++) begin : g_layer
      localparam int NN = 2**l;
      localparam int LO = NN - 1;

      logic [NN-1:0][INPUT_WIDTH-1:0]   d;
      logic [2*NN-1:0][INPUT_WIDTH-1:0] q;
      logic [NUM_NODES-1:LO]            rnd_s;

      if (l == 0) begin : g_in
         assign d = x_in_i;
         always_comb begin
            for (int k = 0; k < NUM_NODES; k++) rnd_s[k] = lfsr_q[k % 16];
         end
      end else begin : g_in
         assign d = g_layer[l-1].q;
         always_ff @(posedge clk_i) begin
            if (reset_i)            rnd_s <= '0;
            else if (vld_pipe[l-1]) rnd_s <= g_layer[l-1].rnd_s[NUM_NODES-1:LO];
         end
      end

      for (genvar n = 0; n < NN; n++) begin : g_node
         dem_switch_node #(.WIDTH(INPUT_WIDTH)) u_node (
            .clk_i      (clk_i),
            .reset_i    (reset_i),
            .valid_i    (vld_pipe[l]),
            .mode_i     (mode_pipe[l]),
            .rand_bit_i (rnd_s[LO+n]),
            .x_i        (d[n]),
            .a_o        (q[2*n]),
            .b_o        (q[2*n+1])
         );
      end
   end

   assign leaves  = g_layer[NUM_LAYERS-1].q;
   assign x_out_o = leaves;

   always_comb begin
      leaf_sum = '0;
      for (int j = 0; j < NUM_LEAVES; j++)
         leaf_sum = leaf_sum + {{NUM_LAYERS{leaves[j][INPUT_WIDTH-1]}}, leaves[j]};
   end

   assign valid_o     = vld_pipe[NUM_LAYERS];
   assign zero_flag_o = vld_pipe[NUM_LAYERS] & (x_pipe[NUM_LAYERS] == '0);
   assign mode_err_o  = vld_pipe[NUM_LAYERS] & (mode_pipe[NUM_LAYERS] == DEM_ILLEGAL);
   assign sum_err_o   = vld_pipe[NUM_LAYERS] &
                        (leaf_sum != {{NUM_LAYERS{x_pipe[NUM_LAYERS][INPUT_WIDTH-1]}},
                                      x_pipe[NUM_LAYERS]});

endmodule

// File: tb/tb_dem_switch_tree.sv
module tb_dem_switch_tree;

   localparam int W  = 16;
   localparam int L  = 3;
   localparam int NL = 8;

   logic                clk = 1'b0;
   logic                reset_i, valid_i;
   logic [1:0]          mode_i;
   logic signed [W-1:0] x_in_i;
   logic                valid_o, zero_flag_o, mode_err_o, sum_err_o;
   logic [NL*W-1:0]     x_out_o;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [127:0] lv;
      logic         merr;
      logic         zf;
   } exp_t;

   exp_t        expq[$];
   exp_t        e;
   logic [15:0] mlfsr;
   logic [2:0]  evp;
   logic [15:0] xr;
   logic [1:0]  m;
   int          n_sent, cyc;

   always #5 clk = ~clk;

   dem_switch_tree #(.INPUT_WIDTH(W), .NUM_LAYERS(L), .LFSR_SEED(16'hACE1)) dut (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .valid_i     (valid_i),
      .mode_i      (mode_i),
      .x_in_i      (x_in_i),
      .valid_o     (valid_o),
      .x_out_o     (x_out_o),
      .zero_flag_o (zero_flag_o),
      .mode_err_o  (mode_err_o),
      .sum_err_o   (sum_err_o)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      valid_i = 1'b0;
      step();
      reset_i = 1'b0;
   endtask

   // one sample, then idle until it reaches the output
   task automatic send(input logic [1:0] md, input int x);
      valid_i = 1'b1;
      mode_i  = md;
      x_in_i  = 16'(x);
      step();
      valid_i = 1'b0;
      step();
      chk("early_valid", valid_o, 1'b0);
      step();
   endtask

   function automatic logic [127:0] lv(input int l0, l1, l2, l3, l4, l5, l6, l7);
      int t[8];
      logic [127:0] r;
      t = '{l0, l1, l2, l3, l4, l5, l6, l7};
      r = '0;
      for (int j = 0; j < 8; j++) r[j*16 +: 16] = t[j][15:0];
      return r;
   endfunction

   // reference tree: children (x+s)/2 and (x-s)/2, exact since x+s is even
   function automatic logic [127:0] model(input int x, input logic [1:0] md, input logic [15:0] lf);
      int cur[8];
      int nxt[8];
      int s;
      logic [127:0] r;
      cur = '{default: 0};
      nxt = '{default: 0};
      cur[0] = x;
      for (int l = 0; l < 3; l++) begin
         for (int n = 0; n < (1 << l); n++) begin
            s = 0;
            if (cur[n] % 2 != 0) s = (md == 2'b10 && !lf[((1 << l) - 1 + n) % 16]) ? -1 : 1;
            nxt[2*n]   = (cur[n] + s) / 2;
            nxt[2*n+1] = (cur[n] - s) / 2;
         end
         cur = nxt;
      end
      r = '0;
      for (int j = 0; j < 8; j++) r[j*16 +: 16] = cur[j][15:0];
      return r;
   endfunction

   task automatic rnd_observe();
      evp = {evp[1:0], valid_i};
      chk("rnd_valid", valid_o, evp[2]);
      chk("rnd_sumerr", sum_err_o, 1'b0);
      if (valid_o) begin
         chk("rnd_qnonempty", expq.size() > 0, 1'b1);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("rnd_leaves", x_out_o, e.lv);
            chk("rnd_modeerr", mode_err_o, e.merr);
            chk("rnd_zero", zero_flag_o, e.zf);
         end
      end
   endtask

   initial begin
      reset_i = 1'b1;
      valid_i = 1'b0;
      mode_i  = 2'b00;
      x_in_i  = '0;
      step();
      step();
      chk("rst_valid", valid_o, 1'b0);
      chk("rst_leaves", x_out_o, '0);
      chk("rst_flags", {zero_flag_o, mode_err_o, sum_err_o}, 3'b000);
      reset_i = 1'b0;

      // static, x=7
      send(2'b00, 7);
      chk("x7_valid", valid_o, 1'b1);
      chk("x7_leaves", x_out_o, lv(1, 1, 1, 1, 1, 1, 1, 0));
      chk("x7_sumerr", sum_err_o, 1'b0);
      step();
      chk("x7_pulse", valid_o, 1'b0);
      chk("x7_hold", x_out_o, lv(1, 1, 1, 1, 1, 1, 1, 0));

      // shaped, back-to-back x=1
      do_reset();
      valid_i = 1'b1; mode_i = 2'b01; x_in_i = 16'sd1;
      step();
      step();
      valid_i = 1'b0;
      step();
      chk("sh1_leaves", x_out_o, lv(1, 0, 0, 0, 0, 0, 0, 0));
      step();
      chk("sh2_valid", valid_o, 1'b1);
      chk("sh2_leaves", x_out_o, lv(0, 0, 0, 0, 1, 0, 0, 0));

      // static boundaries
      send(2'b00, -1);
      chk("m1_leaves", x_out_o, lv(0, 0, 0, 0, 0, 0, 0, -1));
      send(2'b00, 32767);
      chk("max_leaves", x_out_o, lv(4096, 4096, 4096, 4096, 4096, 4096, 4096, 4095));
      chk("max_sumerr", sum_err_o, 1'b0);
      send(2'b00, -32768);
      chk("min_leaves", x_out_o, lv(-4096, -4096, -4096, -4096, -4096, -4096, -4096, -4096));
      chk("min_flags", {zero_flag_o, sum_err_o}, 2'b00);
      send(2'b00, 0);
      chk("zero_flag", zero_flag_o, 1'b1);
      chk("zero_leaves", x_out_o, '0);

      // shaped with idle gap: idle cycles must not advance state
      do_reset();
      send(2'b01, 1);
      chk("gap1_leaves", x_out_o, lv(1, 0, 0, 0, 0, 0, 0, 0));
      repeat (5) step();
      send(2'b01, 1);
      chk("gap2_leaves", x_out_o, lv(0, 0, 0, 0, 1, 0, 0, 0));

      // reset with two samples in flight
      valid_i = 1'b1; mode_i = 2'b01; x_in_i = 16'sd1;
      step();
      step();
      reset_i = 1'b1;
      valid_i = 1'b0;
      step();
      chk("mid_rst_valid", valid_o, 1'b0);
      chk("mid_rst_leaves", x_out_o, '0);
      chk("mid_rst_flags", {zero_flag_o, mode_err_o, sum_err_o}, 3'b000);
      reset_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("mid_rst_novalid", valid_o, 1'b0);
      end
      send(2'b01, 1);
      chk("mid_rst_fresh", x_out_o, lv(1, 0, 0, 0, 0, 0, 0, 0));

      // random mode against reference model, with some illegal-mode samples
      do_reset();
      mlfsr  = 16'hACE1;
      evp    = '0;
      n_sent = 0;
      cyc    = 0;
      while (n_sent < 1000 && cyc < 6000) begin
         cyc++;
         if ($urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 19))
               0:       xr = 16'h0000;
               1:       xr = 16'h8000;
               2:       xr = 16'h7FFF;
               3:       xr = 16'hFFFF;
               default: xr = 16'($urandom);
            endcase
            m = (n_sent % 37 == 5) ? 2'b11 : 2'b10;
            e.lv   = model(int'($signed(xr)), m, mlfsr);
            e.merr = (m == 2'b11);
            e.zf   = (xr == 16'h0000);
            expq.push_back(e);
            mlfsr   = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
            valid_i = 1'b1;
            mode_i  = m;
            x_in_i  = xr;
            n_sent++;
         end else begin
            valid_i = 1'b0;
            mode_i  = 2'($urandom);
            x_in_i  = 16'($urandom);
         end
         step();
         rnd_observe();
      end
      chk("rnd_sent", n_sent, 1000);
      valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         rnd_observe();
      end
      chk("rnd_drained", expq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
